// File: rtl/motor_pwm_pkg.sv
// Shared definitions for the motor PWM timebase/configuration block:
// FSM state encodings, register-map addresses and the default minimum period.
package motor_pwm_pkg;

    // Run/stop/fault sequencer states; codes are visible on the state port.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_STOPPING = 2'd2,
        ST_FAULT    = 2'd3
    } state_t;

    // Register-map addresses above the per-phase duty range.
    localparam logic [3:0] ADDR_PERIOD   = 4'd8;
    localparam logic [3:0] ADDR_DEADBAND = 4'd9;
    localparam logic [3:0] ADDR_COMMIT   = 4'd15;

    // Smallest period the timebase will ever run with.
    localparam int PMIN_DEFAULT = 2;

endpackage

// File: rtl/motor_pwm_shadow_reg.sv
// One shadow/active register pair.
// The shadow copy absorbs software writes (with an optional floor applied on
// write); the active copy only changes on a transfer strobe, optionally
// limited to a ceiling value, so the running PWM never sees a half-updated set.
module motor_pwm_shadow_reg #(
    parameter int              SIZE    = 16,
    parameter logic [SIZE-1:0] RST_VAL = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr,
    input  logic [SIZE-1:0] wr_data,
    input  logic [SIZE-1:0] floor_val,
    input  logic            xfer,
    input  logic            ceil_en,
    input  logic [SIZE-1:0] ceil_val,
    output logic [SIZE-1:0] shadow,
    output logic [SIZE-1:0] active
);

    // Shadow copy: captures writes, raised to floor_val when smaller.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow <= RST_VAL;
        end else if (wr) begin
            shadow <= (wr_data < floor_val) ? floor_val : wr_data;
        end
    end

    // Active copy: loads the shadow on transfer, limited to ceil_val if enabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active <= RST_VAL;
        end else if (xfer) begin
            active <= (ceil_en && (shadow > ceil_val)) ? ceil_val : shadow;
        end
    end

endmodule

// File: rtl/motor_pwm_timebase_ctrl.sv
// Shared timebase and configuration sequencer for a bank of PWM phases.
// Produces the common up-counter and wrap pulse, double-buffers period,
// deadband and per-phase duty so new settings land only at a period boundary,
// and sequences the common phase enable through run/stop/fault.
module motor_pwm_timebase_ctrl
    import motor_pwm_pkg::*;
#(
    parameter int SIZE = 16,
    parameter int NPH  = 3,
    parameter int PMIN = PMIN_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run_req,
    input  logic                fault,
    input  logic                fault_clr,
    input  logic                wr_en,
    input  logic [3:0]          wr_addr,
    input  logic [SIZE-1:0]     wr_data,
    output logic [SIZE-1:0]     counter,
    output logic                wrap,
    output logic [SIZE-1:0]     period_q,
    output logic [SIZE-1:0]     deadband_q,
    output logic [NPH*SIZE-1:0] duty_q,
    output logic                phase_en,
    output logic                update_pending,
    output logic                fault_latched,
    output logic [1:0]          state
);

    localparam logic [SIZE-1:0] PMIN_V = SIZE'(PMIN);

    state_t          state_q;
    state_t          state_d;
    logic [SIZE-1:0] counter_q;
    logic [SIZE-1:0] counter_d;
    logic            fault_latched_q;
    logic            fault_latched_d;
    logic            pending_q;

    logic            counting;
    logic            wrap_cond;
    logic            xfer;
    logic            commit_wr;
    logic            period_wr;
    logic            deadband_wr;
    logic [NPH-1:0]  duty_wr;
    logic [SIZE-1:0] period_last;
    logic [SIZE-1:0] period_shadow;

    logic [SIZE-1:0] duty_active [NPH];
    logic [SIZE-1:0] duty_shadow [NPH];
    logic [SIZE-1:0] deadband_shadow;

    // Shadow copies of duty and deadband are only needed inside the pairs.
    logic [NPH*SIZE+SIZE-1:0] unused_shadows;

    // Write decode and timing qualifiers shared by the datapath and FSM.
    assign period_last = period_q - SIZE'(1);
    assign counting    = (state_q == ST_RUN) || (state_q == ST_STOPPING);
    assign wrap_cond   = counting && (counter_q == period_last);
    assign commit_wr   = wr_en && (wr_addr == ADDR_COMMIT);
    assign period_wr   = wr_en && (wr_addr == ADDR_PERIOD);
    assign deadband_wr = wr_en && (wr_addr == ADDR_DEADBAND);

    // A committed set moves to the active copies straight away when idle,
    // but only at the period boundary while the timebase is running.
    assign xfer = pending_q && ((state_q == ST_IDLE) || wrap_cond);

    // Period pair: floored at PMIN on write, no ceiling on transfer.
    motor_pwm_shadow_reg #(
        .SIZE    (SIZE),
        .RST_VAL (PMIN_V)
    ) u_period (
        .clk       (clk),
        .rst       (rst),
        .wr        (period_wr),
        .wr_data   (wr_data),
        .floor_val (PMIN_V),
        .xfer      (xfer),
        .ceil_en   (1'b0),
        .ceil_val  ('0),
        .shadow    (period_shadow),
        .active    (period_q)
    );

    // Deadband pair: stored unmodified.
    motor_pwm_shadow_reg #(
        .SIZE    (SIZE),
        .RST_VAL ('0)
    ) u_deadband (
        .clk       (clk),
        .rst       (rst),
        .wr        (deadband_wr),
        .wr_data   (wr_data),
        .floor_val ('0),
        .xfer      (xfer),
        .ceil_en   (1'b0),
        .ceil_val  ('0),
        .shadow    (deadband_shadow),
        .active    (deadband_q)
    );

    // Duty pairs: each limited to the period being transferred alongside it,
    // so a phase can never be asked for more than 100% of the new period.
    for (genvar n = 0; n < NPH; n++) begin : g_duty
        assign duty_wr[n] = wr_en && (wr_addr == 4'(n));

        motor_pwm_shadow_reg #(
            .SIZE    (SIZE),
            .RST_VAL ('0)
        ) u_duty (
            .clk       (clk),
            .rst       (rst),
            .wr        (duty_wr[n]),
            .wr_data   (wr_data),
            .floor_val ('0),
            .xfer      (xfer),
            .ceil_en   (1'b1),
            .ceil_val  (period_shadow),
            .shadow    (duty_shadow[n]),
            .active    (duty_active[n])
        );

        assign duty_q[n*SIZE +: SIZE]              = duty_active[n];
        assign unused_shadows[n*SIZE +: SIZE]      = duty_shadow[n];
    end

    assign unused_shadows[NPH*SIZE +: SIZE] = deadband_shadow;

    // Commit flag: a commit write always wins, so a commit landing on the
    // wrap cycle survives the transfer and applies at the following wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= 1'b0;
        end else if (commit_wr) begin
            pending_q <= 1'b1;
        end else if (xfer) begin
            pending_q <= 1'b0;
        end
    end

    // State, counter and sticky fault registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            counter_q       <= '0;
            fault_latched_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            counter_q       <= counter_d;
            fault_latched_q <= fault_latched_d;
        end
    end

    // Next-state, counter and fault-flag logic; fault overrides everything.
    always_comb begin
        state_d         = state_q;
        counter_d       = '0;
        fault_latched_d = fault_latched_q;

        if (counting) begin
            counter_d = wrap_cond ? '0 : counter_q + SIZE'(1);
        end

        unique case (state_q)
            ST_IDLE: begin
                if (run_req) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!run_req) begin
                    state_d = ST_STOPPING;
                end
            end
            ST_STOPPING: begin
                if (run_req) begin
                    state_d = ST_RUN;
                end else if (wrap_cond) begin
                    state_d = ST_IDLE;
                end
            end
            ST_FAULT: begin
                if (fault_clr && !fault) begin
                    state_d         = ST_IDLE;
                    fault_latched_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (fault) begin
            state_d         = ST_FAULT;
            counter_d       = '0;
            fault_latched_d = 1'b1;
        end
    end

    assign counter        = counter_q;
    assign wrap           = wrap_cond;
    assign phase_en       = counting;
    assign update_pending = pending_q;
    assign fault_latched  = fault_latched_q;
    assign state          = state_q;

endmodule

// File: tb/tb_motor_pwm_timebase_ctrl.sv
// Directed bench for motor_pwm_timebase_ctrl: configuration, run, boundary
// updates, graceful stop, fault handling, period clamping, commit-on-wrap and
// asynchronous reset. Inputs change and outputs are sampled on the falling edge.
module tb_motor_pwm_timebase_ctrl;

    localparam int SIZE = 16;
    localparam int NPH  = 3;

    logic                clk = 1'b0;
    logic                rst;
    logic                run_req;
    logic                fault;
    logic                fault_clr;
    logic                wr_en;
    logic [3:0]          wr_addr;
    logic [SIZE-1:0]     wr_data;
    logic [SIZE-1:0]     counter;
    logic                wrap;
    logic [SIZE-1:0]     period_q;
    logic [SIZE-1:0]     deadband_q;
    logic [NPH*SIZE-1:0] duty_q;
    logic                phase_en;
    logic                update_pending;
    logic                fault_latched;
    logic [1:0]          state;

    int checks   = 0;
    int failures = 0;

    motor_pwm_timebase_ctrl #(
        .SIZE (SIZE),
        .NPH  (NPH),
        .PMIN (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .run_req        (run_req),
        .fault          (fault),
        .fault_clr      (fault_clr),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .counter        (counter),
        .wrap           (wrap),
        .period_q       (period_q),
        .deadband_q     (deadband_q),
        .duty_q         (duty_q),
        .phase_en       (phase_en),
        .update_pending (update_pending),
        .fault_latched  (fault_latched),
        .state          (state)
    );

    // 10 ns system clock.
    always #5 clk = ~clk;

    // Compare one observed value against its hand-computed expectation.
    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance n falling edges.
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One-cycle shadow register write.
    task automatic apply_write(input logic [3:0] addr, input logic [SIZE-1:0] data);
        wr_en   = 1'b1;
        wr_addr = addr;
        wr_data = data;
        @(negedge clk);
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
    endtask

    initial begin
        rst       = 1'b1;
        run_req   = 1'b0;
        fault     = 1'b0;
        fault_clr = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        step(2);

        // Reset values
        check_output("rst_counter", 32'(counter), 0);
        check_output("rst_period", 32'(period_q), 2);
        check_output("rst_deadband", 32'(deadband_q), 0);
        check_output("rst_duty", 32'(duty_q[31:0]), 0);
        check_output("rst_phase_en", 32'(phase_en), 0);
        check_output("rst_wrap", 32'(wrap), 0);
        check_output("rst_pending", 32'(update_pending), 0);
        check_output("rst_fault", 32'(fault_latched), 0);
        check_output("rst_state", 32'(state), 0);
        rst = 1'b0;
        step(1);

        // 1: configure in IDLE, then run
        apply_write(4'd8, 16'd1000);
        apply_write(4'd0, 16'd500);
        apply_write(4'd9, 16'd33);
        check_output("t1_write_no_active", 32'(period_q), 2);
        apply_write(4'd15, 16'd0);
        check_output("t1_pending", 32'(update_pending), 1);
        step(1);
        check_output("t1_period", 32'(period_q), 1000);
        check_output("t1_duty0", 32'(duty_q[0 +: SIZE]), 500);
        check_output("t1_deadband", 32'(deadband_q), 33);
        check_output("t1_pending_clr", 32'(update_pending), 0);
        run_req = 1'b1;
        step(1);
        check_output("t1_state_run", 32'(state), 1);
        check_output("t1_phase_en", 32'(phase_en), 1);
        check_output("t1_counter0", 32'(counter), 0);
        step(1);
        check_output("t1_counter1", 32'(counter), 1);
        step(998);
        check_output("t1_counter999", 32'(counter), 999);
        check_output("t1_wrap", 32'(wrap), 1);
        step(1);
        check_output("t1_counter_wrapped", 32'(counter), 0);
        check_output("t1_wrap_low", 32'(wrap), 0);

        // 2: duty update while running lands at the wrap
        step(200);
        apply_write(4'd0, 16'd250);
        apply_write(4'd15, 16'd0);
        check_output("t2_counter", 32'(counter), 202);
        check_output("t2_duty_held", 32'(duty_q[0 +: SIZE]), 500);
        check_output("t2_pending", 32'(update_pending), 1);
        step(797);
        check_output("t2_counter999", 32'(counter), 999);
        check_output("t2_duty_held_wrap", 32'(duty_q[0 +: SIZE]), 500);
        step(1);
        check_output("t2_counter0", 32'(counter), 0);
        check_output("t2_duty_new", 32'(duty_q[0 +: SIZE]), 250);
        check_output("t2_pending_clr", 32'(update_pending), 0);

        // 3: graceful stop, then stop aborted by re-asserting run_req
        step(400);
        run_req = 1'b0;
        step(1);
        check_output("t3_stopping", 32'(state), 2);
        check_output("t3_counter401", 32'(counter), 401);
        check_output("t3_phase_en_stop", 32'(phase_en), 1);
        step(598);
        check_output("t3_counter999", 32'(counter), 999);
        check_output("t3_phase_en_999", 32'(phase_en), 1);
        step(1);
        check_output("t3_idle", 32'(state), 0);
        check_output("t3_phase_en_off", 32'(phase_en), 0);
        check_output("t3_counter_idle", 32'(counter), 0);
        run_req = 1'b1;
        step(1);
        check_output("t3_rerun_counter", 32'(counter), 0);
        step(400);
        run_req = 1'b0;
        step(1);
        check_output("t3_stopping2", 32'(state), 2);
        step(299);
        check_output("t3_counter700", 32'(counter), 700);
        run_req = 1'b1;
        step(1);
        check_output("t3_back_to_run", 32'(state), 1);
        check_output("t3_counter701", 32'(counter), 701);

        // 4: fault shutdown and clear
        step(422);
        check_output("t4_counter123", 32'(counter), 123);
        fault = 1'b1;
        step(1);
        check_output("t4_state_fault", 32'(state), 3);
        check_output("t4_phase_en", 32'(phase_en), 0);
        check_output("t4_counter", 32'(counter), 0);
        check_output("t4_latched", 32'(fault_latched), 1);
        fault_clr = 1'b1;
        step(1);
        fault_clr = 1'b0;
        check_output("t4_clr_ignored", 32'(state), 3);
        fault   = 1'b0;
        run_req = 1'b0;
        step(1);
        check_output("t4_still_fault", 32'(state), 3);
        check_output("t4_still_latched", 32'(fault_latched), 1);
        fault_clr = 1'b1;
        step(1);
        fault_clr = 1'b0;
        check_output("t4_idle", 32'(state), 0);
        check_output("t4_latched_clr", 32'(fault_latched), 0);

        // 5: period clamped to PMIN, duty clamped to period
        apply_write(4'd8, 16'd1);
        apply_write(4'd1, 16'd60000);
        apply_write(4'd15, 16'd0);
        step(1);
        check_output("t5_period_pmin", 32'(period_q), 2);
        check_output("t5_duty1_clamp", 32'(duty_q[SIZE +: SIZE]), 2);
        check_output("t5_duty0_clamp", 32'(duty_q[0 +: SIZE]), 2);
        run_req = 1'b1;
        step(1);
        check_output("t5_c0", 32'(counter), 0);
        check_output("t5_w0", 32'(wrap), 0);
        step(1);
        check_output("t5_c1", 32'(counter), 1);
        check_output("t5_w1", 32'(wrap), 1);
        step(1);
        check_output("t5_c2", 32'(counter), 0);
        check_output("t5_w2", 32'(wrap), 0);
        step(1);
        check_output("t5_c3", 32'(counter), 1);

        // 6: commit coincident with wrap
        apply_write(4'd8, 16'd10);
        apply_write(4'd15, 16'd0);
        check_output("t6_pre_wrap", 32'(wrap), 1);
        apply_write(4'd9, 16'd77);
        check_output("t6_period10", 32'(period_q), 10);
        check_output("t6_db_old", 32'(deadband_q), 33);
        check_output("t6_duty1_10", 32'(duty_q[SIZE +: SIZE]), 10);
        apply_write(4'd15, 16'd0);
        step(8);
        check_output("t6_c9", 32'(counter), 9);
        check_output("t6_pending", 32'(update_pending), 1);
        apply_write(4'd15, 16'd0);
        check_output("t6_db_77", 32'(deadband_q), 77);
        check_output("t6_pending_kept", 32'(update_pending), 1);
        check_output("t6_c0", 32'(counter), 0);
        apply_write(4'd9, 16'd44);
        check_output("t6_db_still_77", 32'(deadband_q), 77);
        step(8);
        check_output("t6_c9b", 32'(counter), 9);
        step(1);
        check_output("t6_db_44", 32'(deadband_q), 44);
        check_output("t6_pending_clr", 32'(update_pending), 0);

        // Asynchronous reset mid-run
        step(3);
        #2;
        rst = 1'b1;
        #1;
        check_output("ar_phase_en", 32'(phase_en), 0);
        check_output("ar_state", 32'(state), 0);
        check_output("ar_period", 32'(period_q), 2);
        check_output("ar_deadband", 32'(deadband_q), 0);
        run_req = 1'b0;
        step(1);
        rst = 1'b0;
        step(1);
        check_output("ar_counter", 32'(counter), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
